// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: owner encodings and default widths.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  // Owner of a RAM cycle; also used as the read-return tag
  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_CPU  = 2'b01,
    OWNER_DBG  = 2'b10
  } owner_t;

endpackage

// File: rtl/ram_arb_rd_tag_pipe.sv
// RD_LAT-deep shift register of owner tags. A tag enters with the grant
// decision and exits in the cycle whose closing edge captures ram_rdata.
module ram_arb_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk_qzt,
  input  logic   clr,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage [DEPTH];

  // Shift tags one stage per cycle; clear discards every in-flight read
  always_ff @(posedge clk_qzt) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= OWNER_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port block RAM between the CPU data port and the
// debug/loader port, one access per cycle, and steers read data back to the
// requester that issued each read.
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: replaces fixed CPU priority and
// the debug starvation guard with alternating (last-winner) arbitration.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [3:0]  MAX_WAIT = 4'd8
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        arb_owner
);

  logic              cpu_elig;
  logic              dbg_elig;
  logic              cpu_win;
  logic              dbg_win;
  owner_t            win_owner;
  owner_t            push_tag;
  owner_t            exit_tag;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A requester whose grant is showing this cycle is not eligible again yet
  assign cpu_elig = cpu_req & ~cpu_gnt;
  assign dbg_elig = dbg_req & ~dbg_gnt;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_dbg;

  assign dbg_win = dbg_elig & (~cpu_elig | ~last_dbg);
  assign cpu_win = cpu_elig & ~dbg_win;

  // Remember who was granted last; starts at debug so the CPU wins first
  always_ff @(posedge clk_qzt) begin
    if (reset)        last_dbg <= 1'b1;
    else if (dbg_win) last_dbg <= 1'b1;
    else if (cpu_win) last_dbg <= 1'b0;
  end
`else
  logic [3:0] wait_cnt;

  assign dbg_win = dbg_elig & (~cpu_elig | (wait_cnt == MAX_WAIT));
  assign cpu_win = cpu_elig & ~dbg_win;

  // Count cycles debug has been eligible but passed over, saturating
  always_ff @(posedge clk_qzt) begin
    if (reset)                          wait_cnt <= '0;
    else if (!dbg_req || dbg_win)       wait_cnt <= '0;
    else if (dbg_elig && wait_cnt < MAX_WAIT) wait_cnt <= wait_cnt + 4'd1;
  end
`endif

  // Select the winner's access and the tag it pushes into the return pipe
  always_comb begin
    win_owner = OWNER_NONE;
    sel_we    = 1'b0;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    push_tag  = OWNER_NONE;
    if (dbg_win) begin
      win_owner = OWNER_DBG;
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end else if (cpu_win) begin
      win_owner = OWNER_CPU;
      sel_we    = cpu_we;
    end
    if (win_owner != OWNER_NONE && !sel_we) push_tag = win_owner;
  end

  ram_arb_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk_qzt (clk_qzt),
    .clr     (reset),
    .tag_in  (push_tag),
    .tag_out (exit_tag)
  );

  // Registered grant, RAM strobe and read-return outputs
  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      arb_owner  <= OWNER_NONE;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_gnt   <= cpu_win;
      dbg_gnt   <= dbg_win;
      ram_en    <= cpu_win | dbg_win;
      ram_we    <= sel_we;
      arb_owner <= win_owner;
      if (cpu_win || dbg_win) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      cpu_rvalid <= (exit_tag == OWNER_CPU);
      dbg_rvalid <= (exit_tag == OWNER_DBG);
      if (exit_tag == OWNER_CPU) cpu_rdata <= ram_rdata;
      if (exit_tag == OWNER_DBG) dbg_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance a uses RD_LAT=1, instance b
// RD_LAT=2; each has its own behavioural RAM. Honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a signals
  logic       cpu_req_a = 0, cpu_we_a = 0, dbg_req_a = 0, dbg_we_a = 0;
  logic [7:0] cpu_addr_a = 0, cpu_wdata_a = 0, dbg_addr_a = 0, dbg_wdata_a = 0;
  logic       cpu_gnt_a, cpu_rvalid_a, dbg_gnt_a, dbg_rvalid_a, ram_en_a, ram_we_a;
  logic [7:0] cpu_rdata_a, dbg_rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
  logic [1:0] arb_owner_a;

  // Instance b signals
  logic       cpu_req_b = 0, cpu_we_b = 0, dbg_req_b = 0, dbg_we_b = 0;
  logic [7:0] cpu_addr_b = 0, cpu_wdata_b = 0, dbg_addr_b = 0, dbg_wdata_b = 0;
  logic       cpu_gnt_b, cpu_rvalid_b, dbg_gnt_b, dbg_rvalid_b, ram_en_b, ram_we_b;
  logic [7:0] cpu_rdata_b, dbg_rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
  logic [1:0] arb_owner_b;

  // Preload port shared by both RAM models
  logic       pre_we = 0;
  logic [7:0] pre_addr = 0, pre_data = 0;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .MAX_WAIT(4'd8)) dut_a (
    .clk_qzt(clk), .reset(reset),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
    .cpu_gnt(cpu_gnt_a), .cpu_rvalid(cpu_rvalid_a), .cpu_rdata(cpu_rdata_a),
    .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a),
    .dbg_gnt(dbg_gnt_a), .dbg_rvalid(dbg_rvalid_a), .dbg_rdata(dbg_rdata_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a), .arb_owner(arb_owner_a)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .MAX_WAIT(4'd8)) dut_b (
    .clk_qzt(clk), .reset(reset),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
    .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b),
    .dbg_gnt(dbg_gnt_b), .dbg_rvalid(dbg_rvalid_b), .dbg_rdata(dbg_rdata_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b), .arb_owner(arb_owner_b)
  );

  // RAM model a: data for the strobed address is presented within the access cycle
  logic [7:0] mem_a [256];
  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (ram_en_a && ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
  end
  assign ram_rdata_a = mem_a[ram_addr_a];

  // RAM model b: one extra register stage on read data
  logic [7:0] mem_b [256];
  logic [7:0] rd_q_b;
  always @(posedge clk) begin
    if (pre_we) mem_b[pre_addr] <= pre_data;
    else if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    if (ram_en_b && !ram_we_b) rd_q_b <= mem_b[ram_addr_b];
  end
  assign ram_rdata_b = rd_q_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
  endtask

  task automatic do_reset();
    cpu_req_a = 0; dbg_req_a = 0; cpu_req_b = 0; dbg_req_b = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [39:0] sa, sb;
    do_reset();
    sa = {cpu_gnt_a, cpu_rvalid_a, cpu_rdata_a, dbg_gnt_a, dbg_rvalid_a, dbg_rdata_a,
          ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, arb_owner_a};
    sb = {cpu_gnt_b, cpu_rvalid_b, cpu_rdata_b, dbg_gnt_b, dbg_rvalid_b, dbg_rdata_b,
          ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b, arb_owner_b};
    total++; if (sa !== 40'h0) begin bad++; $display("FAIL reset_outs_a: got %h want 0", sa); end
    total++; if (sb !== 40'h0) begin bad++; $display("FAIL reset_outs_b: got %h want 0", sb); end
  endtask

  task automatic test_cpu_read();
    preload(8'h10, 8'hA5);
    do_reset();
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 8'h10;
    tick();
    total++; if ({cpu_gnt_a, dbg_gnt_a, ram_en_a, ram_we_a} !== 4'b1010) begin bad++;
      $display("FAIL cpu_rd_gnt: got gnt/dgnt/en/we=%b want 1010", {cpu_gnt_a, dbg_gnt_a, ram_en_a, ram_we_a}); end
    total++; if (ram_addr_a !== 8'h10) begin bad++; $display("FAIL cpu_rd_addr: got %h want 10", ram_addr_a); end
    total++; if (arb_owner_a !== 2'b01) begin bad++; $display("FAIL cpu_rd_owner: got %b want 01", arb_owner_a); end
    cpu_req_a = 0;
    tick();
    total++; if (cpu_rvalid_a !== 1'b1 || cpu_rdata_a !== 8'hA5) begin bad++;
      $display("FAIL cpu_rd_return: got v=%b d=%h want v=1 d=a5", cpu_rvalid_a, cpu_rdata_a); end
    total++; if ({cpu_gnt_a, ram_en_a, arb_owner_a, dbg_rvalid_a, dbg_gnt_a, dbg_rdata_a} !== 14'h0) begin bad++;
      $display("FAIL cpu_rd_idle: got %h want 0", {cpu_gnt_a, ram_en_a, arb_owner_a, dbg_rvalid_a, dbg_gnt_a, dbg_rdata_a}); end
    tick();
    total++; if (cpu_rvalid_a !== 1'b0 || cpu_rdata_a !== 8'hA5) begin bad++;
      $display("FAIL cpu_rd_hold: got v=%b d=%h want v=0 d=a5", cpu_rvalid_a, cpu_rdata_a); end
  endtask

  task automatic test_dbg_write_read();
    do_reset();
    dbg_req_a = 1; dbg_we_a = 1; dbg_addr_a = 8'h20; dbg_wdata_a = 8'h3C;
    tick();
    total++; if ({dbg_gnt_a, ram_en_a, ram_we_a, ram_wdata_a, arb_owner_a} !== {3'b111, 8'h3C, 2'b10}) begin bad++;
      $display("FAIL dbg_wr_issue: got g=%b en=%b we=%b wd=%h own=%b want 1 1 1 3c 10",
               dbg_gnt_a, ram_en_a, ram_we_a, ram_wdata_a, arb_owner_a); end
    dbg_req_a = 0;
    tick();
    total++; if (dbg_gnt_a !== 1'b0 || dbg_rvalid_a !== 1'b0) begin bad++;
      $display("FAIL dbg_wr_norv: got g=%b rv=%b want 0 0", dbg_gnt_a, dbg_rvalid_a); end
    dbg_req_a = 1; dbg_we_a = 0;
    tick();
    total++; if (dbg_gnt_a !== 1'b1 || ram_we_a !== 1'b0 || ram_addr_a !== 8'h20) begin bad++;
      $display("FAIL dbg_rd_issue: got g=%b we=%b a=%h want 1 0 20", dbg_gnt_a, ram_we_a, ram_addr_a); end
    dbg_req_a = 0;
    tick();
    total++; if (dbg_rvalid_a !== 1'b1 || dbg_rdata_a !== 8'h3C || cpu_rvalid_a !== 1'b0) begin bad++;
      $display("FAIL dbg_rd_return: got v=%b d=%h cv=%b want 1 3c 0", dbg_rvalid_a, dbg_rdata_a, cpu_rvalid_a); end
    tick();
    total++; if (dbg_rvalid_a !== 1'b0) begin bad++; $display("FAIL dbg_rd_single: got v=%b want 0", dbg_rvalid_a); end
  endtask

  task automatic test_starvation();
    int dbg_cycle;
    logic [7:0] exp_addr;
    logic exp_cpu, exp_dbg;
    do_reset();
    dbg_cycle = 0;
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 8'h40;
    dbg_req_a = 1; dbg_we_a = 0; dbg_addr_a = 8'h50;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_cpu = (c % 2 == 1);
      exp_dbg = (c == 2);
      total++; if (cpu_gnt_a !== exp_cpu || dbg_gnt_a !== exp_dbg) begin bad++;
        $display("FAIL starve_gnt c%0d: got cpu=%b dbg=%b want cpu=%b dbg=%b", c, cpu_gnt_a, dbg_gnt_a, exp_cpu, exp_dbg); end
      exp_addr = exp_cpu ? (8'h40 + 8'((c - 1) / 2)) : 8'h50;
      if (exp_cpu || exp_dbg) begin
        total++; if (ram_addr_a !== exp_addr) begin bad++;
          $display("FAIL starve_addr c%0d: got %h want %h", c, ram_addr_a, exp_addr); end
      end
      if (cpu_gnt_a) cpu_addr_a = cpu_addr_a + 8'd1;
      if (dbg_gnt_a) begin dbg_req_a = 0; dbg_cycle = c; end
    end
    total++; if (dbg_cycle < 1 || dbg_cycle > 10) begin bad++;
      $display("FAIL starve_bound: got dbg grant cycle %0d want 1..10", dbg_cycle); end
    cpu_req_a = 0; dbg_req_a = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    cpu_req_a = 1; cpu_we_a = 1; cpu_addr_a = 8'h70; cpu_wdata_a = 8'h01;
    dbg_req_a = 1; dbg_we_a = 1; dbg_addr_a = 8'h71; dbg_wdata_a = 8'h02;
    tick();
    total++; if (cpu_gnt_a !== 1'b1 || dbg_gnt_a !== 1'b0) begin bad++;
      $display("FAIL withdraw_first: got cpu=%b dbg=%b want 1 0", cpu_gnt_a, dbg_gnt_a); end
    cpu_req_a = 0; dbg_req_a = 0;
    tick();
    total++; if ({ram_en_a, dbg_gnt_a, cpu_gnt_a, arb_owner_a} !== 5'b0 || ram_addr_a !== 8'h70) begin bad++;
      $display("FAIL withdraw_idle: got en=%b dg=%b cg=%b own=%b a=%h want 0 0 0 00 70",
               ram_en_a, dbg_gnt_a, cpu_gnt_a, arb_owner_a, ram_addr_a); end
  endtask

  task automatic test_contention();
    logic first_dbg, want_dbg;
    logic [1:0] want_own;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    first_dbg = 1'b1;
`else
    first_dbg = 1'b0;
`endif
    do_reset();
    cpu_req_a = 1; cpu_we_a = 1; cpu_addr_a = 8'h80; cpu_wdata_a = 8'h55;
    tick();
    total++; if (cpu_gnt_a !== 1'b1) begin bad++; $display("FAIL cont_solo: got cpu_gnt=%b want 1", cpu_gnt_a); end
    cpu_req_a = 0;
    tick();
    cpu_req_a = 1; dbg_req_a = 1; dbg_we_a = 1; dbg_addr_a = 8'h81; dbg_wdata_a = 8'h66;
    for (int i = 0; i < 8; i++) begin
      tick();
      want_dbg = (i % 2 == 0) ? first_dbg : ~first_dbg;
      want_own = want_dbg ? 2'b10 : 2'b01;
      total++; if (dbg_gnt_a !== want_dbg || cpu_gnt_a !== ~want_dbg || arb_owner_a !== want_own) begin bad++;
        $display("FAIL cont_alt i%0d: got cpu=%b dbg=%b own=%b want own=%b", i, cpu_gnt_a, dbg_gnt_a, arb_owner_a, want_own); end
    end
    cpu_req_a = 0; dbg_req_a = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [39:0] sa;
    do_reset();
    cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 8'h10;
    tick();
    total++; if (cpu_gnt_a !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", cpu_gnt_a); end
    cpu_req_a = 0; dbg_req_a = 1; dbg_we_a = 0;
    reset = 1;
    tick();
    sa = {cpu_gnt_a, cpu_rvalid_a, cpu_rdata_a, dbg_gnt_a, dbg_rvalid_a, dbg_rdata_a,
          ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, arb_owner_a};
    total++; if (sa !== 40'h0) begin bad++; $display("FAIL rmid_outs: got %h want 0", sa); end
`ifndef RAM_ARB_ROUND_ROBIN_EN
    total++; if (dut_a.wait_cnt !== 4'd0) begin bad++; $display("FAIL rmid_wait: got %0d want 0", dut_a.wait_cnt); end
`endif
    dbg_req_a = 0;
    reset = 0;
    tick();
    total++; if (cpu_rvalid_a !== 1'b0 || dbg_rvalid_a !== 1'b0) begin bad++;
      $display("FAIL rmid_norv: got cv=%b dv=%b want 0 0", cpu_rvalid_a, dbg_rvalid_a); end
  endtask

  task automatic test_back_to_back();
    preload(8'h01, 8'h11);
    preload(8'h02, 8'h22);
    do_reset();
    cpu_req_b = 1; cpu_we_b = 0; cpu_addr_b = 8'h01;
    dbg_req_b = 1; dbg_we_b = 0; dbg_addr_b = 8'h02;
    tick();
    total++; if (cpu_gnt_b !== 1'b1 || dbg_gnt_b !== 1'b0) begin bad++;
      $display("FAIL b2b_g1: got cpu=%b dbg=%b want 1 0", cpu_gnt_b, dbg_gnt_b); end
    cpu_req_b = 0;
    tick();
    total++; if (dbg_gnt_b !== 1'b1 || ram_addr_b !== 8'h02 || cpu_rvalid_b !== 1'b0) begin bad++;
      $display("FAIL b2b_g2: got dbg=%b a=%h cv=%b want 1 02 0", dbg_gnt_b, ram_addr_b, cpu_rvalid_b); end
    dbg_req_b = 0;
    tick();
    total++; if (cpu_rvalid_b !== 1'b1 || cpu_rdata_b !== 8'h11 || dbg_rvalid_b !== 1'b0) begin bad++;
      $display("FAIL b2b_cpu_ret: got cv=%b cd=%h dv=%b want 1 11 0", cpu_rvalid_b, cpu_rdata_b, dbg_rvalid_b); end
    tick();
    total++; if (dbg_rvalid_b !== 1'b1 || dbg_rdata_b !== 8'h22 || cpu_rvalid_b !== 1'b0) begin bad++;
      $display("FAIL b2b_dbg_ret: got dv=%b dd=%h cv=%b want 1 22 0", dbg_rvalid_b, dbg_rdata_b, cpu_rvalid_b); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write_read();
    test_starvation();
    test_withdraw();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
